// File: rtl/fifo_drain_serializer_if.sv
// Stream bundle between the FIFO read side, the drain stage and its sink.
// master: the serializer side; slave: the FIFO plus sink environment.
interface fifo_drain_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  out_ready,
    output fifo_read_en,
    output out_valid,
    output out_data,
    output out_last,
    output busy
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output out_ready,
    input  fifo_read_en,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  busy
  );
endinterface

// File: rtl/fifo_drain_serializer.sv
// FIFO drain stage: pops words and emits RATIO beats each with out_last.
// FIFO_DRAIN_PREFETCH_EN adds a prefetch word so words stream bubble-free.
module fifo_drain_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input logic clk,
  input logic rst,
  fifo_drain_serializer_if.master bus
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;

  if (RATIO < 2 || (DATA_WIDTH % OUT_WIDTH) != 0) begin : g_cfg_err
    $fatal(1, "fifo_drain_serializer: bad DATA_WIDTH/OUT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         beat_cnt;
  logic                  last;
  logic                  xfer;
  logic                  pop;
  logic                  load_fifo;
  logic                  advance;
`ifdef FIFO_DRAIN_PREFETCH_EN
  logic [DATA_WIDTH-1:0] pre_reg;
  logic                  pre_valid;
  logic                  fill_pre;
  logic                  load_pre;
`endif

  assign last = (beat_cnt == CW'(RATIO - 1));
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = (state == SEND) && last;
  assign xfer = bus.out_valid && bus.out_ready;
  assign bus.out_data = (MSB_FIRST != 0)
    ? shift_reg[DATA_WIDTH-1 -: OUT_WIDTH]
    : shift_reg[OUT_WIDTH-1:0];
  // Pop is masked by rst so the FIFO is never drained while in reset.
  assign bus.fifo_read_en = pop && !rst;
`ifdef FIFO_DRAIN_PREFETCH_EN
  assign bus.busy = (state == SEND) || pre_valid;
`else
  assign bus.busy = (state == SEND);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_fifo = 1'b0;
    advance   = 1'b0;
`ifdef FIFO_DRAIN_PREFETCH_EN
    fill_pre  = 1'b0;
    load_pre  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        pop = !bus.fifo_empty;
        if (pop) begin
          load_fifo = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
`ifdef FIFO_DRAIN_PREFETCH_EN
        pop = !pre_valid && !bus.fifo_empty;
        unique case (1'b1)
          (xfer && last && pre_valid): load_pre  = 1'b1;
          (xfer && last && pop):       load_fifo = 1'b1;
          (xfer && last):              state_nxt = IDLE;
          default: begin
            fill_pre = pop;
            advance  = xfer;
          end
        endcase
`else
        if (xfer) begin
          if (last) state_nxt = IDLE;
          else      advance   = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else if (load_fifo) begin
      shift_reg <= bus.fifo_read_data;
      beat_cnt  <= '0;
`ifdef FIFO_DRAIN_PREFETCH_EN
    end else if (load_pre) begin
      shift_reg <= pre_reg;
      beat_cnt  <= '0;
`endif
    end else if (advance) begin
      shift_reg <= (MSB_FIRST != 0)
        ? (shift_reg << OUT_WIDTH)
        : (shift_reg >> OUT_WIDTH);
      beat_cnt  <= beat_cnt + 1'b1;
    end
  end

`ifdef FIFO_DRAIN_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg   <= '0;
      pre_valid <= 1'b0;
    end else if (fill_pre) begin
      pre_reg   <= bus.fifo_read_data;
      pre_valid <= 1'b1;
    end else if (load_pre) begin
      pre_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: LSB-first and MSB-first instances
// against a queue FIFO model and a beat scoreboard.
module tb_fifo_drain_serializer;

  localparam int DW = 32;
  localparam int OW = 8;
  localparam int RATIO = DW / OW;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  fifo_drain_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) ia ();
  fifo_drain_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) ib ();

  assign ia.out_ready = rdy;
  assign ib.out_ready = rdy;

  fifo_drain_serializer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(0)
  ) dut_lsb (.clk(clk), .rst(rst), .bus(ia));

  fifo_drain_serializer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1)
  ) dut_msb (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    logic [DW-1:0] word;
    int            stall;
    logic [DW-1:0] exp_lsb;
    logic [DW-1:0] exp_msb;
  } vec_t;

  vec_t vec[4];

  logic [DW-1:0] q[2][$];
  logic [OW:0]   e[2][$];
  logic [OW-1:0] cd[2][$];
  logic          cl[2][$];
  int            ct[2][$];
  int            pops[2];

  logic          s_re[2], s_v[2], s_l[2];
  logic [OW-1:0] s_d[2];
  logic          p_v[2], p_x[2], p_l[2];
  logic [OW-1:0] p_d[2];
  logic          s_rst, s_rdy, p_rst;

  int ncyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, ncyc);
    end
  endtask

  function automatic logic [OW-1:0] beat_of(logic [DW-1:0] w,
                                            int msb, int i);
    int k;
    k = (msb != 0) ? (RATIO - 1 - i) : i;
    return OW'(w >> (k * OW));
  endfunction

  task automatic drive();
    ia.fifo_empty = (q[0].size() == 0);
    ia.fifo_read_data = (q[0].size() == 0) ? '0 : q[0][0];
    ib.fifo_empty = (q[1].size() == 0);
    ib.fifo_read_data = (q[1].size() == 0) ? '0 : q[1][0];
  endtask

  task automatic push(logic [DW-1:0] w);
    q[0].push_back(w);
    q[1].push_back(w);
    drive();
    #1;
  endtask

  task automatic clear_caps();
    for (int d = 0; d < 2; d++) begin
      cd[d].delete();
      cl[d].delete();
      ct[d].delete();
    end
  endtask

  task automatic cycle();
    int sc;
    sc = ncyc;
    s_re[0] = ia.fifo_read_en; s_v[0] = ia.out_valid;
    s_d[0] = ia.out_data;      s_l[0] = ia.out_last;
    s_re[1] = ib.fifo_read_en; s_v[1] = ib.out_valid;
    s_d[1] = ib.out_data;      s_l[1] = ib.out_last;
    s_rst = rst;
    s_rdy = rdy;
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() == 0 && s_re[d])
        chk("pop_while_empty", 64'(s_re[d]), 64'd0);
      if (p_v[d] && !p_x[d] && !p_rst) begin
        chk("hold_valid", 64'(s_v[d]), 64'd1);
        chk("hold_data", 64'(s_d[d]), 64'(p_d[d]));
        chk("hold_last", 64'(s_l[d]), 64'(p_l[d]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      logic x;
      if (s_rst) e[d].delete();
      if (s_re[d] && q[d].size() > 0) begin
        if (!s_rst)
          for (int i = 0; i < RATIO; i++)
            e[d].push_back({i == RATIO - 1, beat_of(q[d][0], d, i)});
        void'(q[d].pop_front());
        pops[d]++;
      end
      x = s_v[d] && s_rdy && !s_rst;
      if (x) begin
        if (e[d].size() == 0) begin
          chk("unexpected_beat", 64'(s_d[d]), 64'hDEAD);
        end else begin
          chk("beat_data", 64'(s_d[d]), 64'(e[d][0][OW-1:0]));
          chk("beat_last", 64'(s_l[d]), 64'(e[d][0][OW]));
          void'(e[d].pop_front());
        end
        cd[d].push_back(s_d[d]);
        cl[d].push_back(s_l[d]);
        ct[d].push_back(sc);
      end
      p_v[d] = s_v[d];
      p_x[d] = x;
      p_d[d] = s_d[d];
      p_l[d] = s_l[d];
    end
    p_rst = s_rst;
    drive();
    #1;
  endtask

  task automatic drain(int bound);
    int c;
    c = 0;
    while ((q[0].size() + q[1].size() + e[0].size() + e[1].size() != 0
            || ia.out_valid || ib.out_valid) && c < bound) begin
      cycle();
      c++;
    end
    chk("drain_timeout", 64'(c < bound), 64'd1);
  endtask

  function automatic logic [DW-1:0] pack(int d, int from);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < RATIO; i++)
      if (from + i < cd[d].size())
        r = r | (DW'(cd[d][from + i]) << (i * OW));
    return r;
  endfunction

  initial begin
    int t0, c, pa, pb, span;
    logic [RATIO-1:0] lp;
    vec[0] = '{32'hA1B2C3D4, 0, 32'hA1B2C3D4, 32'hD4C3B2A1};
    vec[1] = '{32'hA1B2C3D4, 1, 32'hA1B2C3D4, 32'hD4C3B2A1};
    vec[2] = '{32'hFF00FF00, 0, 32'hFF00FF00, 32'h00FF00FF};
    vec[3] = '{32'h12345678, 1, 32'h12345678, 32'h78563412};
    for (int d = 0; d < 2; d++) begin
      p_v[d] = 0; p_x[d] = 0; p_d[d] = '0; p_l[d] = 0; pops[d] = 0;
    end
    p_rst = 1'b1;
    rst = 1'b1;
    rdy = 1'b1;
    push(32'h5A5A0F0F);

    for (int r = 0; r < 3; r++) begin
      chk("rst_read_en_a", 64'(ia.fifo_read_en), 64'd0);
      chk("rst_read_en_b", 64'(ib.fifo_read_en), 64'd0);
      if (r > 0) begin
        chk("rst_valid_a", 64'(ia.out_valid), 64'd0);
        chk("rst_busy_b", 64'(ib.busy), 64'd0);
        chk("rst_last_a", 64'(ia.out_last), 64'd0);
        chk("rst_data_a", 64'(ia.out_data), 64'd0);
      end
      cycle();
    end
    rst = 1'b0;
    #1;
    chk("first_pop_a", 64'(ia.fifo_read_en), 64'd1);
    chk("first_pop_b", 64'(ib.fifo_read_en), 64'd1);
    drain(40);

    for (int v = 0; v < 4; v++) begin
      logic stalled;
      clear_caps();
      rdy = 1'b1;
      pa = pops[0];
      pb = pops[1];
      t0 = ncyc;
      push(vec[v].word);
      stalled = 0;
      c = 0;
      while (!(cd[0].size() == RATIO && cd[1].size() == RATIO) && c < 60) begin
        if (vec[v].stall != 0 && !stalled && cd[0].size() == 1) begin
          stalled = 1;
          rdy = 1'b0;
          repeat (5) begin
            chk("stall_data_a", 64'(ia.out_data), 64'(vec[v].exp_lsb[15:8]));
            chk("stall_data_b", 64'(ib.out_data), 64'(vec[v].exp_msb[15:8]));
            chk("stall_valid", 64'(ia.out_valid & ib.out_valid), 64'd1);
            cycle();
          end
          rdy = 1'b1;
        end
        cycle();
        c++;
      end
      chk("vec_timeout", 64'(c < 60), 64'd1);
      chk("vec_beats_lsb", 64'(pack(0, 0)), 64'(vec[v].exp_lsb));
      chk("vec_beats_msb", 64'(pack(1, 0)), 64'(vec[v].exp_msb));
      lp = '0;
      for (int i = 0; i < RATIO && i < cl[0].size(); i++) lp[i] = cl[0][i];
      chk("vec_last_pattern", 64'(lp), 64'({1'b1, {(RATIO-1){1'b0}}}));
      chk("vec_one_pop", 64'(pops[0] - pa + pops[1] - pb), 64'd2);
      if (vec[v].stall == 0 && ct[0].size() == RATIO) begin
        chk("vec_latency", 64'(ct[0][0] - t0), 64'd1);
        chk("vec_consecutive", 64'(ct[0][RATIO-1] - ct[0][0]), 64'(RATIO-1));
      end
      drain(20);
    end

    clear_caps();
    rdy = 1'b1;
    q[0].push_back(32'hCAFEF00D);
    q[1].push_back(32'hCAFEF00D);
    push(32'h0BADBEEF);
    c = 0;
    while (cd[0].size() < 2 * RATIO && c < 40) begin
      cycle();
      c++;
    end
    span = (cd[0].size() == 2 * RATIO) ? ct[0][2*RATIO-1] - ct[0][0] + 1 : -1;
`ifdef FIFO_DRAIN_PREFETCH_EN
    chk("b2b_span", 64'(span), 64'(2 * RATIO));
`else
    chk("b2b_span", 64'(span), 64'(2 * RATIO + 1));
`endif
    chk("b2b_second_word", 64'(pack(0, RATIO)), 64'h0BADBEEF);
    drain(20);

    clear_caps();
    rdy = 1'b1;
    pa = pops[0];
    push(32'h99887766);
    c = 0;
    while (cd[0].size() < 2 && c < 20) begin
      cycle();
      c++;
    end
    rst = 1'b1;
    push(32'h11223344);
    chk("midrst_read_en_a", 64'(ia.fifo_read_en), 64'd0);
    chk("midrst_read_en_b", 64'(ib.fifo_read_en), 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("midrst_valid_a", 64'(ia.out_valid), 64'd0);
    chk("midrst_valid_b", 64'(ib.out_valid), 64'd0);
    drain(30);
    chk("midrst_beats", 64'(cd[0].size()), 64'(2 + RATIO));
    chk("midrst_new_lsb", 64'(pack(0, 2)), 64'h11223344);
    chk("midrst_new_msb", 64'(pack(1, 2)), 64'h44332211);
    chk("midrst_pops", 64'(pops[0] - pa), 64'd2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 30 && q[0].size() < 4)
        push(DW'($urandom));
      rdy = ($urandom_range(0, 99) < 70);
      cycle();
    end
    rdy = 1'b1;
    drain(200);
    chk("end_scoreboard_a", 64'(e[0].size()), 64'd0);
    chk("end_scoreboard_b", 64'(e[1].size()), 64'd0);
    chk("end_busy", 64'(ia.busy | ib.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
